// File: rtl/nspi_pkg.sv
// Shared definitions for the multi-lane SPI transmitter/receiver pair.
package nspi_pkg;

  localparam int SPI_SIZE_DEF       = 8;
  localparam int CHANNEL_NUMBER_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } nspi_rx_state_t;

endpackage

// File: rtl/nspi_sync.sv
// Multi-bit, STAGES-deep flip-flop synchroniser for asynchronous inputs.
// Each bit is synchronised independently; the bits are not treated as a bus.
module nspi_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_r;

  // Shift the asynchronous input down the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/nspi_rx.sv
// Multi-lane SPI (mode 0) receiver. Oversamples spi_clk in the clk domain,
// shifts one bit per lane on each rising edge, and presents completed words
// on a valid/ready interface with overrun and timeout reporting.
module nspi_rx
  import nspi_pkg::*;
#(
  parameter int CHANNEL_NUMBER = CHANNEL_NUMBER_DEF,
  parameter int SPI_SIZE       = SPI_SIZE_DEF,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_clk,
  input  logic [CHANNEL_NUMBER-1:0] spi_mosi,
  output logic [SPI_SIZE-1:0]       data_out [CHANNEL_NUMBER-1:0],
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      overrun,
  output logic                      frame_error,
  output logic                      busy
);

  localparam int BW = (SPI_SIZE > 2) ? $clog2(SPI_SIZE) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(SPI_SIZE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                      sclk_sync_s;
  logic [CHANNEL_NUMBER-1:0] mosi_sync_s;
  logic                      sclk_prev_r;
  logic                      rise_s;

  nspi_rx_state_t state_r, state_s;
  logic [BW-1:0]  bcnt_r, bcnt_s;
  logic [TW-1:0]  tcnt_r, tcnt_s;

  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] shift_r, shift_s;
  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] shifted_s;
  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] hold_r, hold_s;
  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] data_r, data_s;

  logic pend_r, pend_s;
  logic valid_r, valid_s;
  logic overrun_r, overrun_s;
  logic frame_r, frame_s;
  logic busy_r;

  nspi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_clk (
    .clk (clk),
    .rst (rst),
    .d   (spi_clk),
    .q   (sclk_sync_s)
  );

  nspi_sync #(.WIDTH(CHANNEL_NUMBER), .STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d   (spi_mosi),
    .q   (mosi_sync_s)
  );

  assign rise_s = sclk_sync_s & ~sclk_prev_r;

  // Per-lane shift value with the freshly sampled bit inserted.
  always_comb begin
    shifted_s = shift_r;
    for (int l = 0; l < CHANNEL_NUMBER; l++) begin
      if (MSB_FIRST != 0) begin
        shifted_s[l] = {shift_r[l][SPI_SIZE-2:0], mosi_sync_s[l]};
      end else begin
        shifted_s[l] = {mosi_sync_s[l], shift_r[l][SPI_SIZE-1:1]};
      end
    end
  end

  // Next-state, counters, commit and handshake. A completed word is parked in
  // hold_r for one cycle and committed from there, so the shift register is
  // free for a back-to-back word immediately.
  always_comb begin
    state_s   = state_r;
    bcnt_s    = bcnt_r;
    tcnt_s    = tcnt_r;
    shift_s   = shift_r;
    hold_s    = hold_r;
    pend_s    = 1'b0;
    data_s    = data_r;
    valid_s   = valid_r;
    overrun_s = 1'b0;
    frame_s   = 1'b0;

    case (state_r)
      IDLE: begin
        tcnt_s = '0;
        if (rise_s) begin
          shift_s = shifted_s;
          bcnt_s  = BW'(1);
          state_s = SHIFT;
        end else begin
          bcnt_s  = '0;
        end
      end
      SHIFT: begin
        if (rise_s) begin
          tcnt_s = '0;
          if (bcnt_r == BIT_LAST) begin
            hold_s  = shifted_s;
            pend_s  = 1'b1;
            shift_s = '0;
            bcnt_s  = '0;
            state_s = IDLE;
          end else begin
            shift_s = shifted_s;
            bcnt_s  = bcnt_r + BW'(1);
          end
        end else if (tcnt_r == TMO_LAST) begin
          frame_s = 1'b1;
          shift_s = '0;
          bcnt_s  = '0;
          tcnt_s  = '0;
          state_s = IDLE;
        end else begin
          tcnt_s  = tcnt_r + TW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        bcnt_s  = '0;
        tcnt_s  = '0;
        shift_s = '0;
      end
    endcase

    if (pend_r) begin
      if (!valid_r || rx_ready) begin
        data_s  = hold_r;
        valid_s = 1'b1;
      end else begin
        overrun_s = 1'b1;
      end
    end else if (valid_r && rx_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_r <= 1'b0;
      state_r     <= IDLE;
      bcnt_r      <= '0;
      tcnt_r      <= '0;
      shift_r     <= '0;
      hold_r      <= '0;
      pend_r      <= 1'b0;
      data_r      <= '0;
      valid_r     <= 1'b0;
      overrun_r   <= 1'b0;
      frame_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      sclk_prev_r <= sclk_sync_s;
      state_r     <= state_s;
      bcnt_r      <= bcnt_s;
      tcnt_r      <= tcnt_s;
      shift_r     <= shift_s;
      hold_r      <= hold_s;
      pend_r      <= pend_s;
      data_r      <= data_s;
      valid_r     <= valid_s;
      overrun_r   <= overrun_s;
      frame_r     <= frame_s;
      busy_r      <= (bcnt_s != '0);
    end
  end

  for (genvar l = 0; l < CHANNEL_NUMBER; l++) begin : g_out
    assign data_out[l] = data_r[l];
  end

  assign rx_valid    = valid_r;
  assign overrun     = overrun_r;
  assign frame_error = frame_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_nspi_rx.sv
// Directed bench for nspi_rx: an MSB-first and an LSB-first receiver share the
// same SPI lines; a monitor counts rx_valid rises and error pulses.
module tb_nspi_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic [1:0] spi_mosi;
  logic       rx_ready;

  logic [7:0] dout  [1:0];
  logic [7:0] dout2 [1:0];
  logic       rx_valid, overrun, frame_error, busy;
  logic       rx_valid2, overrun2, frame_error2, busy2;

  int nchk = 0;
  int nerr = 0;
  int vrise_cnt = 0, ovr_cnt = 0, fe_cnt = 0, ovr2_cnt = 0, fe2_cnt = 0;
  logic vprev = 1'b0;
  logic lat3, lat4;
  int v0, o0, f0;

  always #5 clk = ~clk;

  nspi_rx #(.CHANNEL_NUMBER(2), .SPI_SIZE(8), .MSB_FIRST(1),
            .TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .data_out(dout), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .frame_error(frame_error), .busy(busy));

  nspi_rx #(.CHANNEL_NUMBER(2), .SPI_SIZE(8), .MSB_FIRST(0),
            .TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut_lsb (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .data_out(dout2), .rx_valid(rx_valid2), .rx_ready(rx_ready),
    .overrun(overrun2), .frame_error(frame_error2), .busy(busy2));

  // Event counters for pulses and rx_valid rising edges.
  always @(posedge clk) begin
    if (rx_valid && !vprev) vrise_cnt <= vrise_cnt + 1;
    vprev <= rx_valid;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (overrun2) ovr2_cnt <= ovr2_cnt + 1;
    if (frame_error2) fe2_cnt <= fe2_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send the top n bits (MSB first) of b0/b1; 4 clk low, 4 clk high per bit.
  // When pulse_ready is set, rx_ready is high only in the commit cycle of the last bit.
  task automatic send_bits(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input bit pulse_ready);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = {b1[i], b0[i]};
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      repeat (3) @(negedge clk);
      lat3 = rx_valid;
      if (pulse_ready && i == 0) rx_ready = 1'b1;
      @(negedge clk);
      lat4 = rx_valid;
      if (pulse_ready && i == 0) rx_ready = 1'b0;
      spi_clk = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; spi_clk = 1'b0; spi_mosi = 2'b00; rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data0", {24'd0, dout[0]}, 32'h0);
    chk("rst_data1", {24'd0, dout[1]}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_pulses", {30'd0, overrun, frame_error}, 32'h0);

    // Basic word, ready held high, both bit orders.
    rx_ready = 1'b1;
    v0 = vrise_cnt; o0 = ovr_cnt; f0 = fe_cnt;
    send_bits(8, 8'h0F, 8'hF0, 1'b0);
    chk("lat_minus1", {31'd0, lat3}, 32'h0);
    chk("lat_exact", {31'd0, lat4}, 32'h1);
    repeat (4) @(negedge clk);
    chk("t1_data0", {24'd0, dout[0]}, 32'h0F);
    chk("t1_data1", {24'd0, dout[1]}, 32'hF0);
    chk("t1_vpulses", vrise_cnt - v0, 32'd1);
    chk("t1_ovr", ovr_cnt - o0, 32'd0);
    chk("t1_fe", fe_cnt - f0, 32'd0);
    chk("t1_valid_clr", {31'd0, rx_valid}, 32'h0);
    chk("lsb_data0", {24'd0, dout2[0]}, 32'hF0);
    chk("lsb_data1", {24'd0, dout2[1]}, 32'h0F);
    chk("lsb_valid", {31'd0, rx_valid2}, 32'h0);
    chk("lsb_busy", {31'd0, busy2}, 32'h0);
    chk("lsb_pulses", ovr2_cnt + fe2_cnt, 32'd0);

    // Overrun with ready held low.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_bits(8, 8'h0F, 8'hF0, 1'b0);
    chk("t3_valid1", {31'd0, rx_valid}, 32'h1);
    send_bits(8, 8'hBB, 8'hF0, 1'b0);
    chk("t3_ovr", ovr_cnt - o0, 32'd1);
    chk("t3_valid2", {31'd0, rx_valid}, 32'h1);
    chk("t3_data0", {24'd0, dout[0]}, 32'h0F);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_clr", {31'd0, rx_valid}, 32'h0);

    // Timeout on a 3-bit partial word, then a clean word.
    f0 = fe_cnt;
    send_bits(3, 8'hA0, 8'h00, 1'b0);
    chk("t4_busy", {31'd0, busy}, 32'h1);
    repeat (66) @(negedge clk);
    chk("t4_fe", fe_cnt - f0, 32'd1);
    chk("t4_busy_clr", {31'd0, busy}, 32'h0);
    rx_ready = 1'b0;
    send_bits(8, 8'hBB, 8'h00, 1'b0);
    chk("t4_data0", {24'd0, dout[0]}, 32'hBB);
    chk("t4_data1", {24'd0, dout[1]}, 32'h00);
    chk("t4_fe_once", fe_cnt - f0, 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;

    // Ready raised exactly in the commit cycle of a second word.
    o0 = ovr_cnt;
    send_bits(8, 8'h11, 8'h22, 1'b0);
    chk("t5_valid_a", {31'd0, rx_valid}, 32'h1);
    send_bits(8, 8'h5A, 8'hA5, 1'b1);
    chk("t5_ovr", ovr_cnt - o0, 32'd0);
    chk("t5_valid_b", {31'd0, rx_valid}, 32'h1);
    chk("t5_data0", {24'd0, dout[0]}, 32'h5A);
    chk("t5_data1", {24'd0, dout[1]}, 32'hA5);
    rx_ready = 1'b1;
    @(negedge clk);

    // Reset in the middle of a word.
    v0 = vrise_cnt; o0 = ovr_cnt; f0 = fe_cnt;
    send_bits(4, 8'hFF, 8'hFF, 1'b0);
    chk("t6_busy", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_busy", {31'd0, busy}, 32'h0);
    chk("t6_rst_data", {24'd0, dout[0]}, 32'h00);
    rst = 1'b0;
    send_bits(8, 8'hBB, 8'h44, 1'b0);
    chk("t6_data0", {24'd0, dout[0]}, 32'hBB);
    chk("t6_data1", {24'd0, dout[1]}, 32'h44);
    chk("t6_pulses", (ovr_cnt - o0) + (fe_cnt - f0), 32'd0);
    chk("t6_vpulses", vrise_cnt - v0, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/nspi_rx.md
Name: nspi_rx

Overview:
- Multi-channel SPI receiver (mode 0) that deserialises CHANNEL_NUMBER parallel MOSI lines sharing one SPI clock into SPI_SIZE-bit words.
- It is the counterpart of nspi_tx. It serves as the loopback checker in the Nano9K test project and as the input stage for any board that receives matrix data over the multi-lane bus.
- Runs fully in the system clock domain by oversampling spi_clk, so the system clock must be at least 4x the SPI clock.

Parameters:
- CHANNEL_NUMBER, 2: number of parallel MOSI lanes.
- SPI_SIZE, 8: bits per word per lane (must be >= 2).
- MSB_FIRST, 1: 1 = first received bit lands in the MSB; 0 = first received bit lands in the LSB.
- TIMEOUT_CYCLES, 64: idle clk cycles inside a partial word before the word is aborted (must be >= 4).
- SYNC_STAGES, 2: synchroniser depth on spi_clk and spi_mosi (must be >= 2).

Ports:
- clk, input, 1: system clock. The block has one clock; all logic is on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- spi_clk, input, 1: SPI clock from the transmitter, asynchronous to clk; idle level is low.
- spi_mosi, input, CHANNEL_NUMBER: serial data, one bit per lane.
- data_out, output, unpacked array [CHANNEL_NUMBER-1:0] of SPI_SIZE bits: last completed word on each lane.
- rx_valid, output, 1: data_out holds an unconsumed word.
- rx_ready, input, 1: consumer accepts the word; a transfer happens when rx_valid and rx_ready are both high.
- overrun, output, 1: one-cycle pulse; a completed word was dropped.
- frame_error, output, 1: one-cycle pulse; a partial word was aborted by timeout.
- busy, output, 1: high while a partial word is in progress (bit count != 0).

Behaviour:
- Reset (sync, active high):
  - data_out = 0, rx_valid = 0, overrun = 0, frame_error = 0, busy = 0.
  - Bit counter = 0, timeout counter = 0, shift registers = 0, synchroniser stages = 0.
  - Reset asserted mid-word discards the partial word; no pulses are generated for it.
- Input sampling:
  - spi_clk and spi_mosi each pass through SYNC_STAGES flip-flops.
  - A rising edge is registered sclk_sync high while the previous sclk_sync is low.
  - The synchronised mosi lanes are sampled in the same cycle the edge is detected.
- State machine:
  - IDLE: bit count is 0. A rising edge shifts in bit 0 and moves to SHIFT.
  - SHIFT: each rising edge shifts in one bit on every lane. After bit SPI_SIZE-1 is shifted in, the lanes commit (see Commit) and the state returns to IDLE.
  - Timeout: in SHIFT with no rising edge for TIMEOUT_CYCLES consecutive clk cycles, drop the partial word, pulse frame_error once, and return to IDLE.
  - The timeout counter clears on every rising edge and on entry to IDLE.
- Shift order:
  - MSB_FIRST = 1: shift left, new bit enters bit 0.
  - MSB_FIRST = 0: shift right, new bit enters bit SPI_SIZE-1.
- Commit (cycle after the edge carrying the last bit):
  - If rx_valid = 0, or rx_valid = 1 and rx_ready = 1 in that same cycle: load data_out for all lanes simultaneously and set rx_valid = 1.
  - If rx_valid = 1 and rx_ready = 0: keep the old data_out, drop the new word, and pulse overrun.
- Handshake:
  - rx_valid clears on a transfer unless a commit loads a new word in that same cycle, in which case rx_valid stays high.
  - data_out is stable while rx_valid = 1 and rx_ready = 0.
- Latency: rx_valid rises SYNC_STAGES + 2 clk cycles after the last spi_clk rising edge at the pin (4 cycles with the default SYNC_STAGES).
- Back-to-back words: the next word may start on the very next spi_clk edge; no inter-word gap is required.
- busy = (bit count != 0).

Decomposition:
- Package nspi_pkg holds:
  - the shared defaults SPI_SIZE_DEF = 8 and CHANNEL_NUMBER_DEF = 2, also used by nspi_tx;
  - typedef enum logic {IDLE, SHIFT} nspi_rx_state_t.
- One sub-module: nspi_sync, a parameterised N-bit SYNC_STAGES-deep synchroniser. It is instantiated once for spi_clk and once for the spi_mosi vector.
- Shift, counter and handshake logic stay in nspi_rx.

Test Plan:
- nspi_tx, CHANNEL_NUMBER = 2, MSB_FIRST = 1, sends lane0 = 0x0F and lane1 = 0xF0 with rx_ready held high -> exactly one rx_valid pulse; data_out[0] = 0x0F, data_out[1] = 0xF0; no overrun or frame_error.
- Same stimulus with the receiver's MSB_FIRST = 0 -> data_out[0] = 0xF0, data_out[1] = 0x0F.
- rx_ready held low; send 0x0F/0xF0, then 0xBB/0xF0 -> rx_valid stays high with data_out[0] = 0x0F; one overrun pulse occurs at the second commit. Raising rx_ready then clears rx_valid.
- Drive 3 spi_clk edges, then hold idle for TIMEOUT_CYCLES + 2 clk cycles -> one frame_error pulse and busy returns to 0. A following full word 0xBB is received correctly.
- Assert rx_ready in exactly the commit cycle of a second word -> no overrun, rx_valid stays 1, and data_out updates to the second word.
- Assert rst after 4 bits, release, then send 0xBB -> no pulses during reset, and data_out[0] = 0xBB.
